// File: rtl/div_pkg.sv
// Shared decode constants, FSM state type and defaults for the iterative HI/LO divider.
package div_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    localparam logic [5:0] OP_SPECIAL = 6'd0;
    localparam logic [5:0] FUNCT_DIV  = 6'd26;
    localparam logic [5:0] FUNCT_DIVU = 6'd27;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // True when the instruction word is SPECIAL with the given funct.
    function automatic logic is_op(input logic [31:0] sig, input logic [5:0] funct);
        return (sig[31:26] == OP_SPECIAL) && (sig[5:0] == funct);
    endfunction

endpackage

// File: rtl/div_if.sv
// Request/result bundle between the issuing datapath and div_unit.
interface div_if #(parameter int WIDTH = 32);

    logic                 start;
    logic [31:0]          Signal;
    logic [WIDTH-1:0]     dataA;
    logic [WIDTH-1:0]     dataB;
    logic [2*WIDTH-1:0]   dataOut;
    logic                 busy;
    logic                 done;
    logic                 divZero;

    modport master (
        output start, Signal, dataA, dataB,
        input  dataOut, busy, done, divZero
    );

    modport slave (
        input  start, Signal, dataA, dataB,
        output dataOut, busy, done, divZero
    );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift {rem,quo} left, keep the trial difference if non-negative.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic           ge;

    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        ge       = shifted >= {1'b0, divisor};
        // When ge holds the difference is below divisor, so it fits in WIDTH bits.
        rem_next = ge ? WIDTH'(shifted - {1'b0, divisor}) : shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/div_unit.sv
// Iterative restoring divider returning {remainder, quotient}, one quotient bit per clock.
// Signed div (funct 26) is built only when DIV_SIGNED_EN is defined.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    div_if.slave bus
);

    state_t state, state_nx;

    logic [WIDTH-1:0]   rem_q, rem_nx;
    logic [WIDTH-1:0]   quo_q, quo_nx;
    logic [WIDTH-1:0]   dvs_q, dvs_nx;
    logic [CNT_W-1:0]   cnt_q, cnt_nx;
    logic               dz_q, dz_nx;
    logic [2*WIDTH-1:0] out_q, out_nx;
    logic               busy_q, busy_nx;
    logic               done_q, done_nx;
    logic               divz_q, divz_nx;

    logic               decode_ok;
    logic               accept;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   step_rem, step_quo;
    logic [WIDTH-1:0]   rem_fix, quo_fix, raw_a;
    logic [2*WIDTH-1:0] result;

`ifdef DIV_SIGNED_EN
    logic is_div;
    logic a_neg, b_neg;
    logic neg_q_q, neg_q_nx;
    logic neg_r_q, neg_r_nx;

    assign is_div    = is_op(bus.Signal, FUNCT_DIV);
    assign decode_ok = is_op(bus.Signal, FUNCT_DIVU) || is_div;
    assign a_neg     = is_div & bus.dataA[WIDTH-1];
    assign b_neg     = is_div & bus.dataB[WIDTH-1];
    assign a_mag     = a_neg ? -bus.dataA : bus.dataA;
    assign b_mag     = b_neg ? -bus.dataB : bus.dataB;
    assign rem_fix   = neg_r_q ? -rem_q : rem_q;
    assign quo_fix   = neg_q_q ? -quo_q : quo_q;
    // On divide-by-zero quo_q still holds |dataA|; re-applying the sign restores raw dataA.
    assign raw_a     = neg_r_q ? -quo_q : quo_q;
`else
    assign decode_ok = is_op(bus.Signal, FUNCT_DIVU);
    assign a_mag     = bus.dataA;
    assign b_mag     = bus.dataB;
    assign rem_fix   = rem_q;
    assign quo_fix   = quo_q;
    assign raw_a     = quo_q;
`endif

    assign accept = (state == IDLE) && bus.start && decode_ok;
    assign result = dz_q ? {raw_a, {WIDTH{1'b1}}} : {rem_fix, quo_fix};

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (step_rem),
        .quo_next (step_quo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        rem_nx   = rem_q;
        quo_nx   = quo_q;
        dvs_nx   = dvs_q;
        cnt_nx   = cnt_q;
        dz_nx    = dz_q;
        out_nx   = out_q;
        busy_nx  = busy_q;
        done_nx  = 1'b0;
        divz_nx  = divz_q;
`ifdef DIV_SIGNED_EN
        neg_q_nx = neg_q_q;
        neg_r_nx = neg_r_q;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    rem_nx   = '0;
                    quo_nx   = a_mag;
                    dvs_nx   = b_mag;
                    cnt_nx   = CNT_W'(WIDTH);
                    dz_nx    = (bus.dataB == '0);
                    busy_nx  = 1'b1;
                    divz_nx  = 1'b0;
`ifdef DIV_SIGNED_EN
                    neg_q_nx = a_neg ^ b_neg;
                    neg_r_nx = a_neg;
`endif
                    state_nx = (bus.dataB == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                rem_nx = step_rem;
                quo_nx = step_quo;
                cnt_nx = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_nx = DONE;
            end
            DONE: begin
                out_nx   = result;
                done_nx  = 1'b1;
                busy_nx  = 1'b0;
                divz_nx  = dz_q;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
            out_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            divz_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
`endif
        end else begin
            rem_q   <= rem_nx;
            quo_q   <= quo_nx;
            dvs_q   <= dvs_nx;
            cnt_q   <= cnt_nx;
            dz_q    <= dz_nx;
            out_q   <= out_nx;
            busy_q  <= busy_nx;
            done_q  <= done_nx;
            divz_q  <= divz_nx;
`ifdef DIV_SIGNED_EN
            neg_q_q <= neg_q_nx;
            neg_r_q <= neg_r_nx;
`endif
        end
    end

    assign bus.dataOut = out_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.divZero = divz_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: timeline/arithmetic reference model, per-cycle compare, directed and random ops.
module tb_div_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    div_if bus();
    div_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks   = 0;
    int failures = 0;

    function automatic bit sig_valid(input logic [31:0] s);
        if (s[31:26] != 6'd0) return 1'b0;
        if (s[5:0] == 6'd27) return 1'b1;
`ifdef DIV_SIGNED_EN
        if (s[5:0] == 6'd26) return 1'b1;
`endif
        return 1'b0;
    endfunction

    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
        int sa, sb;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (!sgn) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = a;
        sb = b;
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic checkint(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference timeline: an accepted op at edge acc completes lat edges later.
    int          cyc = 0, acc = 0, lat = 0, next_ok = 0;
    bit          inflt = 1'b0;
    logic [63:0] pend = '0, exp_out = '0;
    bit          pend_dz = 1'b0, exp_dz = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; inflt = 1'b0; next_ok = 0; exp_out = '0; exp_dz = 1'b0;
        end else begin
            cyc++;
            if (bus.start && sig_valid(bus.Signal) && cyc >= next_ok) begin
                acc     = cyc;
                pend_dz = (bus.dataB == 32'd0);
                lat     = pend_dz ? 1 : 33;
                pend    = ref_div(bus.dataA, bus.dataB, bus.Signal[5:0] == 6'd26);
                next_ok = cyc + lat + 1;
                exp_dz  = 1'b0;
                inflt   = 1'b1;
            end
            if (inflt && cyc == acc + lat) begin
                exp_out = pend;
                exp_dz  = pend_dz;
            end
        end
    end

    always @(negedge clk) begin
        bit e_busy, e_done;
        e_busy = inflt && cyc >= acc && cyc < acc + lat;
        e_done = inflt && cyc == acc + lat;
        checkint("busy", int'(bus.busy), int'(e_busy));
        checkint("done", int'(bus.done), int'(e_done));
        checkint("divZero", int'(bus.divZero), int'(exp_dz));
        check64("dataOut", bus.dataOut, exp_out);
    end

    task automatic drive(input logic [31:0] s, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.Signal = s;
        bus.dataA  = a;
        bus.dataB  = b;
        @(negedge clk);
        bus.start  = 1'b0;
    endtask

    task automatic wait_done(output int l, output logic [63:0] res);
        l = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (bus.done) begin
                l = i;
                break;
            end
        end
        res = bus.dataOut;
        if (l < 0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=none required=done within 100 cycles");
        end
    endtask

    task automatic quiet_window(input string name, input int n);
        int dones;
        dones = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        checkint(name, dones, 0);
    endtask

    initial begin
        int          l;
        logic [63:0] res;
        logic [31:0] s, a, b;
        int          sel;

        bus.start = 1'b0; bus.Signal = '0; bus.dataA = '0; bus.dataB = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check64("rst_dataOut", bus.dataOut, 64'h0);
        checkint("rst_busy", int'(bus.busy), 0);
        checkint("rst_done", int'(bus.done), 0);
        #2 rst_n = 1'b1;

        check64("ref_100_7", ref_div(32'd100, 32'd7, 1'b0), 64'h00000002_0000000E);
        check64("ref_max_1", ref_div(32'hFFFF_FFFF, 32'd1, 1'b0), 64'h00000000_FFFFFFFF);
        check64("ref_1234_0", ref_div(32'd1234, 32'd0, 1'b0), 64'h000004D2_FFFFFFFF);
        check64("ref_s_m7_2", ref_div(32'hFFFF_FFF9, 32'd2, 1'b1), 64'hFFFFFFFF_FFFFFFFD);
        check64("ref_s_min_m1", ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), 64'h00000000_80000000);

        drive(32'h0000_001B, 32'd100, 32'd7);
        wait_done(l, res);
        checkint("lat_100_7", l, 33);
        check64("divu_100_7", res, 64'h00000002_0000000E);
        checkint("dz_100_7", int'(bus.divZero), 0);

        drive(32'h0000_001B, 32'hFFFF_FFFF, 32'd1);
        wait_done(l, res);
        check64("divu_max_1", res, 64'h00000000_FFFFFFFF);
        drive(32'h0000_001B, 32'd5, 32'hFFFF_FFFF);
        wait_done(l, res);
        check64("divu_5_max", res, 64'h00000005_00000000);

        drive(32'h0000_001B, 32'd1234, 32'd0);
        wait_done(l, res);
        checkint("lat_div0", l, 1);
        check64("divu_1234_0", res, 64'h000004D2_FFFFFFFF);
        checkint("dz_set", int'(bus.divZero), 1);
        drive(32'h0000_001B, 32'd9, 32'd4);
        checkint("dz_clr_at_accept", int'(bus.divZero), 0);
        wait_done(l, res);
        check64("divu_9_4", res, 64'h00000001_00000002);

        // A second start during RUN must be ignored.
        drive(32'h0000_001B, 32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        drive(32'h0000_001B, 32'd77, 32'd0);
        wait_done(l, res);
        check64("busy_first_result", res, 64'h00000001_0000014D);
        quiet_window("extra_done", 40);

        // Reset in the middle of RUN aborts the op.
        drive(32'h0000_001B, 32'hDEAD_BEEF, 32'h0000_1234);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check64("midrst_dataOut", bus.dataOut, 64'h0);
        checkint("midrst_busy", int'(bus.busy), 0);
        #2 rst_n = 1'b1;
        quiet_window("midrst_no_done", 40);

`ifdef DIV_SIGNED_EN
        drive(32'h0000_001A, 32'hFFFF_FFF9, 32'd2);
        wait_done(l, res);
        check64("div_m7_2", res, 64'hFFFFFFFF_FFFFFFFD);
        drive(32'h0000_001A, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(l, res);
        check64("div_min_m1", res, 64'h00000000_80000000);
        drive(32'h0000_001A, 32'hFFFF_FFF9, 32'd0);
        wait_done(l, res);
        check64("div_m7_0", res, 64'hFFFFFFF9_FFFFFFFF);
`else
        drive(32'h0000_001A, 32'd50, 32'd5);
        checkint("funct26_busy", int'(bus.busy), 0);
        quiet_window("funct26_no_done", 5);
`endif
        drive(32'h0400_001B, 32'd50, 32'd5);
        checkint("badop_busy", int'(bus.busy), 0);
        quiet_window("badop_no_done", 5);

        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6)       s = {6'd0, 20'($urandom), 6'd27};
            else if (sel < 8)  s = {6'd0, 20'($urandom), 6'd26};
            else               s = $urandom;
            a = $urandom;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1, 2, 3: b = $urandom_range(1, 15);
                4:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: b = $urandom;
            endcase
            drive(s, a, b);
            if (sig_valid(s)) begin
                wait_done(l, res);
                check64("rand_result", res, ref_div(a, b, s[5:0] == 6'd26));
            end else begin
                repeat (3) @(negedge clk);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
